// File: rtl/pulse_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_period_meter_pkg
// Description : State encoding and default widths for pulse_period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_period_meter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam int c_default_cnt_w = 16;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ARM  = ST_ARM,
        S_HIGH = ST_HIGH,
        S_LOW  = ST_LOW
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pulse_period_meter_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Multi-flop synchronizer for an asynchronous level plus
//               rising/falling edge detection on the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det
    import pulse_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_sig_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sig_s = r_sync[SYNC_STAGES-1];
    assign rise  = sig_s & ~r_sig_d;
    assign fall  = ~sig_s & r_sig_d;

endmodule
`default_nettype wire

// File: rtl/pulse_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_period_meter
// Description : Measures period and high time (in clk cycles) of an
//               asynchronous periodic input; one strobed result per period.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int CNT_W       = c_default_cnt_w,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic w_sig_s;
    logic w_rise;
    logic w_fall;
    logic w_cnt_max;

    state_e           r_state;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_overflow;
    logic             r_busy;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .sig_s  (w_sig_s),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // Incrementing past all-ones would wrap, so saturation aborts the period.
    assign w_cnt_max = (r_period_cnt == c_cnt_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (!en) begin
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_ARM;
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
                    end
                    S_ARM: begin
                        if (w_rise) begin
                            r_period_cnt <= c_cnt_one;
                            r_high_cnt   <= c_cnt_one;
                            r_state      <= S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        if (w_cnt_max) begin
                            r_overflow <= 1'b1;
                            r_state    <= S_ARM;
                        end else begin
                            r_period_cnt <= r_period_cnt + c_cnt_one;
                            // high_cnt stops on the fall cycle itself
                            if (w_sig_s) begin
                                r_high_cnt <= r_high_cnt + c_cnt_one;
                            end
                            if (w_fall) begin
                                r_state <= S_LOW;
                            end
                        end
                    end
                    S_LOW: begin
                        if (w_rise) begin
                            r_period     <= r_period_cnt;
                            r_high_time  <= r_high_cnt;
                            r_meas_valid <= 1'b1;
                            r_period_cnt <= c_cnt_one;
                            r_high_cnt   <= c_cnt_one;
                            r_state      <= S_HIGH;
                        end else if (w_cnt_max) begin
                            r_overflow <= 1'b1;
                            r_state    <= S_ARM;
                        end else begin
                            r_period_cnt <= r_period_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_period_meter
// Description : Self-checking bench; two instances (16-bit and 4-bit counters)
//               share stimulus and are compared against a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_period_meter;

    localparam int SYNC = 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic en     = 1'b0;
    logic sig_in = 1'b0;

    logic [15:0] a_period, a_high;
    logic        a_valid, a_ovf, a_busy;
    logic [3:0]  b_period, b_high;
    logic        b_valid, b_ovf, b_busy;

    pulse_period_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .period(a_period), .high_time(a_high), .meas_valid(a_valid),
        .overflow(a_ovf), .busy(a_busy)
    );

    pulse_period_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .period(b_period), .high_time(b_high), .meas_valid(b_valid),
        .overflow(b_ovf), .busy(b_busy)
    );

    always #5 clk = ~clk;

    // Model works on cycle timestamps of detected edges: period is the
    // distance between rises, high time the distance from rise to fall.
    typedef struct packed {
        int mode;      // 0 idle, 1 waiting for first rise, 2 measuring
        int t_rise;
        int t_fall;    // -1 until the current period's fall is recorded
        int period;
        int high;
        bit valid;
        bit ovf;
    } mdl_t;

    typedef struct {
        int hi;
        int lo;
        int exp_p;
        int exp_h;
    } vec_t;

    mdl_t       ma, mb;
    logic [7:0] hist;    // hist[k] = sig_in sampled k+1 edges ago
    int         ncyc;
    int         checks = 0;
    int         errors = 0;
    int         strobes_a = 0;
    int         strobes_b = 0;

    function automatic mdl_t step(mdl_t m, int maxc, int n, bit r, bit f, bit e);
        m.valid = 1'b0;
        if (!e) begin
            m.mode = 0;
        end else if (m.mode == 0) begin
            m.mode = 1;
            m.ovf  = 1'b0;
        end else if (m.mode == 1) begin
            if (r) begin
                m.mode   = 2;
                m.t_rise = n;
                m.t_fall = -1;
            end
        end else begin
            if (r && m.t_fall >= 0) begin
                m.period = n - m.t_rise;
                m.high   = m.t_fall - m.t_rise;
                m.valid  = 1'b1;
                m.t_rise = n;
                m.t_fall = -1;
            end else if (n - m.t_rise == maxc) begin
                m.ovf  = 1'b1;
                m.mode = 1;
            end else if (f) begin
                m.t_fall = n;
            end
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma   <= '0;
            mb   <= '0;
            hist <= '0;
        end else begin
            ma   <= step(ma, 65535, ncyc, hist[SYNC-1] & ~hist[SYNC],
                         ~hist[SYNC-1] & hist[SYNC], en);
            mb   <= step(mb, 15, ncyc, hist[SYNC-1] & ~hist[SYNC],
                         ~hist[SYNC-1] & hist[SYNC], en);
            hist <= {hist[6:0], sig_in};
            ncyc <= ncyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a_valid",  32'(a_valid),  32'(ma.valid));
        chk("a_period", 32'(a_period), 32'(ma.period));
        chk("a_high",   32'(a_high),   32'(ma.high));
        chk("a_ovf",    32'(a_ovf),    32'(ma.ovf));
        chk("a_busy",   32'(a_busy),   32'(ma.mode != 0));
        chk("b_valid",  32'(b_valid),  32'(mb.valid));
        chk("b_period", 32'(b_period), 32'(mb.period));
        chk("b_high",   32'(b_high),   32'(mb.high));
        chk("b_ovf",    32'(b_ovf),    32'(mb.ovf));
        chk("b_busy",   32'(b_busy),   32'(mb.mode != 0));
        if (a_valid) strobes_a++;
        if (b_valid) strobes_b++;
    endtask

    task automatic tick(input logic s);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        sig_in = s;
    endtask

    task automatic wave(input int hi, input int lo, input int periods);
        repeat (periods) begin
            repeat (hi) tick(1'b1);
            repeat (lo) tick(1'b0);
        end
    endtask

    task automatic restart();
        en = 1'b0;
        repeat (2) tick(1'b0);
        en = 1'b1;
        strobes_a = 0;
        strobes_b = 0;
    endtask

    initial begin
        vec_t vecs[7];
        int   hi, lo;
        logic [15:0] held_p;

        vecs[0] = '{3, 5, 8, 3};
        vecs[1] = '{1, 1, 2, 1};
        vecs[2] = '{7, 1, 8, 7};
        vecs[3] = '{4, 4, 8, 4};
        vecs[4] = '{2, 13, 15, 2};
        vecs[5] = '{2, 14, 16, 2};
        vecs[6] = '{12, 9, 21, 12};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_period", 32'(a_period), 0);
        chk("rst_high",   32'(a_high),   0);
        chk("rst_valid",  32'(a_valid),  0);
        chk("rst_ovf",    32'(a_ovf),    0);
        chk("rst_busy",   32'(a_busy),   0);
        rst_n = 1'b1;
        repeat (2) tick(1'b0);

        // Table-driven duty/period vectors: 4 periods give 3 strobes
        for (int i = 0; i < 7; i++) begin
            restart();
            wave(vecs[i].hi, vecs[i].lo, 4);
            repeat (5) tick(1'b0);
            chk("tbl_period",  32'(a_period), 32'(vecs[i].exp_p));
            chk("tbl_high",    32'(a_high),   32'(vecs[i].exp_h));
            chk("tbl_strobes", 32'(strobes_a), 3);
        end

        // Overflow on the 4-bit instance: held high after one rise
        restart();
        repeat (25) tick(1'b1);
        chk("ovf_b_set",  32'(b_ovf),  1);
        chk("ovf_b_busy", 32'(b_busy), 1);
        chk("ovf_a_clr",  32'(a_ovf),  0);
        chk("ovf_b_nostrobe", 32'(strobes_b), 0);
        wave(3, 5, 4);
        repeat (5) tick(1'b0);
        chk("ovf_b_period", 32'(b_period), 8);
        chk("ovf_b_high",   32'(b_high),   3);
        chk("ovf_b_sticky", 32'(b_ovf),    1);
        chk("ovf_b_strobes", 32'(strobes_b), 2);

        // Enable drop during LOW, then re-enable
        wave(3, 5, 2);
        repeat (3) tick(1'b1);
        repeat (5) tick(1'b0);
        held_p = a_period;
        en = 1'b0;
        strobes_a = 0;
        tick(1'b0);
        chk("en_busy_a", 32'(a_busy), 0);
        chk("en_busy_b", 32'(b_busy), 0);
        wave(3, 5, 2);
        chk("en_hold_period", 32'(a_period), 32'(held_p));
        chk("en_no_strobe",   32'(strobes_a), 0);
        chk("en_ovf_held",    32'(b_ovf), 1);
        en = 1'b1;
        tick(1'b0);
        chk("en_ovf_cleared", 32'(b_ovf), 0);
        wave(3, 5, 3);
        repeat (5) tick(1'b0);
        chk("en_strobes", 32'(strobes_a), 2);

        // Asynchronous reset while in HIGH
        wave(3, 5, 2);
        repeat (5) tick(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_period", 32'(a_period), 0);
        chk("arst_high",   32'(a_high),   0);
        chk("arst_valid",  32'(a_valid),  0);
        chk("arst_busy",   32'(a_busy),   0);
        chk("arst_b_ovf",  32'(b_ovf),    0);
        @(negedge clk);
        sig_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        strobes_a = 0;
        wave(3, 5, 3);
        repeat (5) tick(1'b0);
        chk("arst_restart_p", 32'(a_period), 8);
        chk("arst_strobes",   32'(strobes_a), 2);

        // Enable while the input is already high
        en = 1'b0;
        repeat (4) tick(1'b1);
        en = 1'b1;
        strobes_a = 0;
        repeat (4) tick(1'b1);
        repeat (6) tick(1'b0);
        wave(2, 4, 2);
        repeat (5) tick(1'b0);
        chk("phase_period",  32'(a_period), 6);
        chk("phase_high",    32'(a_high),   2);
        chk("phase_strobes", 32'(strobes_a), 1);

        // Randomized waveforms with occasional enable drops
        for (int i = 0; i < 300; i++) begin
            hi = $urandom_range(1, 12);
            lo = $urandom_range(1, 12);
            if ($urandom_range(0, 14) == 0) en = ~en;
            else if (!en) en = 1'b1;
            wave(hi, lo, 1);
        end
        repeat (5) tick(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
